// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared constants and types for the two-port RAM arbiter.
//   - Default RAM data/address widths.
//   - FSM state encoding (IDLE=0, ISSUE=1, RESP=2).
//   - pick_winner(): two-way tie-break helper used by arb_select2.
package ram_port_arbiter_pkg;

    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultAddrW = 6;

    localparam logic [1:0] IdleEnc  = 2'd0;
    localparam logic [1:0] IssueEnc = 2'd1;
    localparam logic [1:0] RespEnc  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = IdleEnc,
        StIssue = IssueEnc,
        StResp  = RespEnc
    } state_e;

    // A lone requester always wins; on a tie the one not served last wins.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last);
        return (req0 && req1) ? ~last : req1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_arb_select2.sv
// arb_select2: combinational two-requester winner selection.
// Ports:
//   req0, req1  in   request lines
//   last        in   id of the requester served last (tie goes to the other one)
//   winner      out  selected requester id (0 or 1); 0 when nobody requests
module arb_select2
    import ram_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    always_comb begin
        winner = pick_winner(req0, req1, last);
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: arbitrates two requesters onto one single-port synchronous RAM.
// Configuration macro: ARB_ROUND_ROBIN_EN (defined: round-robin ties; undefined:
// requester 0 always wins ties).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req*/we*/addr*/wdata*    requester 0/1 access request
//   gnt0, gnt1               one-cycle grant pulse (ISSUE state)
//   rvalid0, rvalid1, rdata  one-cycle read response (RESP state)
//   ram_en/ram_we/ram_addr/ram_wdata  RAM command; ram_q  RAM read data
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ADDR_W = DefaultAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
);

    state_e            state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              id_q;
    logic              last;
    logic              winner;
    logic              latch;
    logic              issue;
    logic              resp;

    arb_select2 u_arb_select2 (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (winner)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else if (state_q == StIssue) begin
            ptr_q <= id_q;
        end
    end

    assign last = ptr_q;
`else
    // Pretending requester 1 was always served last gives fixed priority to 0.
    assign last = 1'b1;
`endif

    assign latch = (state_q == StIdle) && (req0 || req1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req0 || req1) state_d = StIssue;
            StIssue: state_d = we_q ? StIdle : StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                we_q    <= winner ? we1 : we0;
                addr_q  <= winner ? addr1 : addr0;
                wdata_q <= winner ? wdata1 : wdata0;
                id_q    <= winner;
            end
        end
    end

    // Outputs are gated by rst so a reset landing on ISSUE never commits a write.
    always_comb begin
        issue     = (state_q == StIssue) && !rst;
        resp      = (state_q == StResp) && !rst;
        ram_en    = issue || resp;
        ram_we    = issue && we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        gnt0      = issue && !id_q;
        gnt1      = issue && id_q;
        rvalid0   = resp && !id_q;
        rvalid1   = resp && id_q;
        rdata     = resp ? ram_q : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a behavioural RAM
// (registered read address) and a grant/read-data scoreboard. Expected tie order
// follows ARB_ROUND_ROBIN_EN.
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_q     (ram_q)
    );

    // Behavioural synchronous RAM: write on enable+we, read data from registered address.
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] raddr_q = '0;

    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en) raddr_q <= ram_addr;
    end
    assign ram_q = mem[raddr_q];

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } rd_t;

    logic exp_gnt [$];
    rd_t  exp_rd  [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, and retire scoreboard entries.
    task automatic tick();
        logic eg;
        rd_t  er;
        @(posedge clk);
        #1;
        check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
        check("rvalid_excl", 32'(rvalid0 & rvalid1), 32'd0);
        if (gnt0 || gnt1) begin
            check("gnt_expected", 32'(exp_gnt.size() != 0), 32'd1);
            if (exp_gnt.size() != 0) begin
                eg = exp_gnt.pop_front();
                check("gnt_id", 32'(gnt1), 32'(eg));
            end
        end
        if (rvalid0 || rvalid1) begin
            check("rvalid_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) begin
                er = exp_rd.pop_front();
                check("rvalid_id", 32'(rvalid1), 32'(er.id));
                check("rdata", 32'(rdata), 32'(er.data));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        check("rst_gnt_rvalid", 32'({gnt0, gnt1, rvalid0, rvalid1}), 32'd0);
        check("rst_ram_en_we", 32'({ram_en, ram_we}), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        tick();

        // Write then read back through requester 0.
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 8'hA5;
        exp_gnt.push_back(1'b0);
        tick();
        check("wr_gnt0", 32'(gnt0), 32'd1);
        check("wr_ram_en", 32'(ram_en), 32'd1);
        check("wr_ram_we", 32'(ram_we), 32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'd5);
        check("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
        req0 = 1'b0; we0 = 1'b0;
        tick();
        check("idle_ram_en", 32'({ram_en, ram_we}), 32'd0);
        check("idle_addr_hold", 32'(ram_addr), 32'd5);
        req0 = 1'b1; addr0 = 6'd5;
        exp_gnt.push_back(1'b0);
        exp_rd.push_back(rd_t'{id: 1'b0, data: 8'hA5});
        tick();
        check("rd_gnt0", 32'(gnt0), 32'd1);
        check("rd_ram_we", 32'(ram_we), 32'd0);
        req0 = 1'b0;
        tick();
        check("rd_rvalid0", 32'(rvalid0), 32'd1);
        check("rd_resp_en", 32'({ram_en, ram_we}), 32'b10);
        tick();
        check("rd_rvalid0_pulse", 32'(rvalid0), 32'd0);

        // Back-to-back writes from requester 1, then read them back.
        req1 = 1'b1; we1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr1 = AW'(i);
            wdata1 = DW'(8'h10 + i);
            exp_gnt.push_back(1'b1);
            tick();
            check("b2b_gnt1", 32'(gnt1), 32'd1);
            check("b2b_addr", 32'(ram_addr), 32'(i));
            check("b2b_wdata", 32'(ram_wdata), 32'(8'h10 + i));
            if (i == 3) req1 = 1'b0;
            tick();
            check("b2b_gap", 32'(gnt1), 32'd0);
        end
        we1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req1 = 1'b1; addr1 = AW'(i);
            exp_gnt.push_back(1'b1);
            exp_rd.push_back(rd_t'{id: 1'b1, data: DW'(8'h10 + i)});
            tick();
            req1 = 1'b0;
            tick();
            check("b2b_rd_rvalid1", 32'(rvalid1), 32'd1);
            tick();
        end

        // Request arriving during requester 0's RESP.
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd2;
        exp_gnt.push_back(1'b0);
        exp_rd.push_back(rd_t'{id: 1'b0, data: 8'h12});
        tick();
        req0 = 1'b0;
        tick();
        check("busy_resp", 32'(rvalid0), 32'd1);
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd3;
        exp_gnt.push_back(1'b1);
        exp_rd.push_back(rd_t'{id: 1'b1, data: 8'h13});
        tick();
        check("busy_idle_no_gnt1", 32'(gnt1), 32'd0);
        tick();
        check("busy_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        tick();
        check("busy_rvalid1", 32'(rvalid1), 32'd1);
        tick();

        // Reset landing on ISSUE of a read.
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd0;
        exp_gnt.push_back(1'b0);
        tick();
        check("rst_mid_gnt0", 32'(gnt0), 32'd1);
        rst = 1'b1; req0 = 1'b0;
        #1;
        check("rst_override_en", 32'({ram_en, ram_we, gnt0}), 32'd0);
        tick();
        check("rst_mid_no_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        check("rst_mid_ram_en", 32'(ram_en), 32'd0);
        check("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_mid_idle", 32'({ram_en, rvalid0, rvalid1}), 32'd0);

        // Tie with both requesters held; first tie after reset must go to requester 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd1;
        for (int k = 0; k < 4; k++) begin
            logic id;
            id = RoundRobin ? logic'(k % 2) : 1'b0;
            exp_gnt.push_back(id);
            exp_rd.push_back(rd_t'{id: id, data: id ? 8'h11 : 8'h10});
        end
        for (int t = 0; t < 11; t++) tick();
        req0 = 1'b0;
        exp_gnt.push_back(1'b1);
        exp_rd.push_back(rd_t'{id: 1'b1, data: 8'h11});
        tick();
        tick();
        check("tie_tail_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        tick();
        tick();

        check("sb_gnt_drained", 32'(exp_gnt.size()), 32'd0);
        check("sb_rd_drained", 32'(exp_rd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data width of the shared RAM.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning address width of the shared RAM.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req0, req1  in  1  access request, requester 0/1
- we0, we1  in  1  1=write, 0=read
- addr0, addr1  in  ADDR_W  access address
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  one-cycle grant pulse
- rvalid0, rvalid1  out  1  one-cycle read-data-valid pulse
- rdata  out  DATA_W  read data, meaningful only while rvalid0/rvalid1 is high
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_q  in  DATA_W  RAM read data, combinational from the RAM's registered read address

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, ISSUE, RESP.
REQ-006 IDLE SHALL behave as follows:
- If no req is high, stay in IDLE.
- Otherwise select a winner, latch the winner's we/addr/wdata and the winner id, and go to ISSUE next cycle.
REQ-007 ISSUE SHALL behave as follows:
- Drive ram_en=1 and ram_we, ram_addr, ram_wdata from the latched values.
- Pulse the winner's gnt for this cycle only.
- Go to RESP if the access is a read; go to IDLE if it is a write.
REQ-008 RESP SHALL behave as follows:
- Drive ram_en=1, ram_we=0.
- Drive rdata=ram_q and pulse the winner's rvalid for this cycle only.
- Go to IDLE.
REQ-009 In IDLE, ram_en and ram_we SHALL be 0, and ram_addr/ram_wdata SHALL hold their last values.
REQ-010 Latency SHALL be: req sampled in cycle N, gnt in N+1, rvalid in N+2 (reads); the RAM write commits at the end of N+1.
REQ-011 Requesters SHALL hold req/we/addr/wdata stable until gnt and drop req the cycle after gnt; a req still high in IDLE after that point is a new request.
REQ-012 gnt0 and gnt1 SHALL never both be high; the same applies to rvalid0 and rvalid1.
REQ-013 A request arriving during ISSUE or RESP SHALL be evaluated only on return to IDLE, and no request SHALL be lost.
REQ-014 Selection with a single requester SHALL grant that requester regardless of history.
REQ-015 Simultaneous req0 and req1 SHALL be resolved per REQ-019/REQ-020.

Reset
REQ-016 While rst=1 at a rising edge, the next state SHALL be IDLE and any in-flight access SHALL be abandoned with no RAM write issued.
REQ-017 Reset values SHALL be:
- gnt0=gnt1=rvalid0=rvalid1=0
- ram_en=ram_we=0
- ram_addr=0, ram_wdata=0, rdata=0
- last-served pointer=1, so requester 0 wins the first tie
REQ-018 rst SHALL override every other input in the same cycle.

Configuration
REQ-019 With ARB_ROUND_ROBIN_EN defined, a tie SHALL be granted to the requester not served last, and the last-served pointer SHALL update at every ISSUE.
REQ-020 Without ARB_ROUND_ROBIN_EN, a tie SHALL always be granted to requester 0 (fixed priority), and the pointer SHALL be omitted.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding constants (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and the default widths DATA_W=8 and ADDR_W=6.
REQ-022 Winner selection SHALL be a sub-module, arb_select2, taking req0, req1 and the pointer and returning the winner id; the FSM and datapath muxing SHALL stay in ram_port_arbiter.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Write then read: req0 write addr=5 wdata=8'hA5, then req0 read addr=5 -> gnt0 at N+1 with ram_en=1, ram_we=1, ram_addr=5; read gives rvalid0 at N+2 with rdata=8'hA5.
- Tie, round robin: req0 and req1 reads held continuously, macro defined -> grant order 0,1,0,1; never gnt0 and gnt1 together.
- Tie, fixed priority: same stimulus, macro undefined -> requester 0 always wins while req0 is held; req1 is granted only after req0 drops.
- Request during busy: req1 asserted during requester 0's RESP -> gnt1 two cycles after RESP (IDLE, then ISSUE); req1 not lost.
- Reset mid-read: rst=1 in ISSUE of a read -> next cycle IDLE, no rvalid, ram_en=0, pointer=1.
- Back-to-back writes: req1 writes addr 0..3 with data 8'h10..8'h13 -> four gnt1 pulses two cycles apart; subsequent reads return 8'h10..8'h13.
